// File: rtl/ualink_mac_lookup_if.sv
// AXI4-Stream beat bundle used on both sides of the ualink MAC lookup stage.
interface ualink_mac_lookup_if #(
  parameter int DATA_W = 64,
  parameter int USER_W = 128
) ();
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tstrb;
  logic [USER_W-1:0]   tuser;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tstrb, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tstrb, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/ualink_mac_lookup.sv
// Output-port lookup: learns source MAC -> port in a small CAM and writes tuser[31:24] on word0.
// Optional statistics counters are built only when MAC_LOOKUP_STATS_EN is defined.
module ualink_mac_lookup #(
  parameter int C_AXIS_DATA_WIDTH  = 64,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_ENTRIES        = 4
) (
  input  logic                axi_aclk,
  input  logic                axi_resetn,
  ualink_mac_lookup_if.slave  s_axis,
  ualink_mac_lookup_if.master m_axis,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count,
  output logic [31:0]         learn_count
);

  localparam int          IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [7:0]  FLOOD = 8'h55;

  typedef enum logic [1:0] {WORD0, WORD1, PAYLOAD} state_t;

  function automatic logic [7:0] flood_mask(input logic [7:0] src);
    return FLOOD & ~src;
  endfunction

  function automatic logic [7:0] filter_port(input logic [7:0] port, input logic [7:0] src);
    return (port == src) ? 8'h00 : port;
  endfunction

  state_t                          state_q, state_d;
  logic                            vld_p1;
  logic [C_AXIS_DATA_WIDTH-1:0]    tdata_p1;
  logic [C_AXIS_DATA_WIDTH/8-1:0]  tstrb_p1;
  logic [C_AXIS_TUSER_WIDTH-1:0]   tuser_p1;
  logic                            tlast_p1;

  logic [7:0]                      src_q;
  logic [15:0]                     mac_lo_q;
  logic [NUM_ENTRIES-1:0]          cam_vld;
  logic [47:0]                     cam_mac  [NUM_ENTRIES];
  logic [7:0]                      cam_port [NUM_ENTRIES];
  logic [IDX_W-1:0]                rp_q;

  logic                            s_ready, s_acc;
  logic                            lkp_acc, lrn_acc, lrn_wr;
  logic [47:0]                     dst_mac, src_mac;
  logic [7:0]                      src_in, lkp_port, dst_port;
  logic                            is_bcast, lkp_hit, lrn_hit;
  logic [IDX_W-1:0]                lrn_idx, lrn_widx, rp_next;
  logic [C_AXIS_TUSER_WIDTH-1:0]   tuser_p0;

  assign s_ready       = !vld_p1 || m_axis.tready;
  assign s_axis.tready = s_ready;
  assign s_acc         = s_axis.tvalid && s_ready;
  assign lkp_acc       = s_acc && (state_q == WORD0);
  assign lrn_acc       = s_acc && (state_q == WORD1);

  // Stage p0: header parse, CAM lookup on word0, CAM learn on word1
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) state_q <= WORD0;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (s_acc) begin
      unique case (state_q)
        WORD0:   state_d = s_axis.tlast ? WORD0 : WORD1;
        WORD1:   state_d = s_axis.tlast ? WORD0 : PAYLOAD;
        PAYLOAD: state_d = s_axis.tlast ? WORD0 : PAYLOAD;
        default: state_d = WORD0;
      endcase
    end
  end

  assign dst_mac  = s_axis.tdata[47:0];
  assign src_in   = s_axis.tuser[23:16];
  assign is_bcast = (dst_mac == BCAST);

  always_comb begin
    lkp_hit  = 1'b0;
    lkp_port = 8'h00;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (cam_vld[i] && (cam_mac[i] == dst_mac)) begin
        lkp_hit  = 1'b1;
        lkp_port = cam_port[i];
      end
    end
  end

  always_comb begin
    dst_port = flood_mask(src_in);
    if (!is_bcast && lkp_hit) dst_port = filter_port(lkp_port, src_in);
  end

  always_comb begin
    tuser_p0 = s_axis.tuser;
    if (state_q == WORD0) tuser_p0[31:24] = dst_port;
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      src_q    <= 8'h00;
      mac_lo_q <= 16'h0000;
    end else if (lkp_acc) begin
      src_q    <= src_in;
      mac_lo_q <= s_axis.tdata[63:48];
    end
  end

  // Source MAC straddles word0/word1; the low half was captured on the word0 accept.
  assign src_mac = {s_axis.tdata[31:0], mac_lo_q};
  assign lrn_wr  = lrn_acc && !src_mac[40];

  always_comb begin
    lrn_hit = 1'b0;
    lrn_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (cam_vld[i] && (cam_mac[i] == src_mac)) begin
        lrn_hit = 1'b1;
        lrn_idx = IDX_W'(i);
      end
    end
  end

  assign lrn_widx = lrn_hit ? lrn_idx : rp_q;
  assign rp_next  = (rp_q == IDX_W'(NUM_ENTRIES - 1)) ? '0 : rp_q + 1'b1;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      cam_vld <= '0;
      rp_q    <= '0;
    end else if (lrn_wr) begin
      cam_vld[lrn_widx] <= 1'b1;
      if (!lrn_hit) rp_q <= rp_next;
    end
  end

  // Entry contents are qualified by cam_vld, so they need no reset.
  always_ff @(posedge axi_aclk) begin
    if (lrn_wr) begin
      cam_mac[lrn_widx]  <= src_mac;
      cam_port[lrn_widx] <= src_q;
    end
  end

  // Stage p1: output register slice
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      vld_p1   <= 1'b0;
      tdata_p1 <= '0;
      tstrb_p1 <= '0;
      tuser_p1 <= '0;
      tlast_p1 <= 1'b0;
    end else if (s_acc) begin
      vld_p1   <= 1'b1;
      tdata_p1 <= s_axis.tdata;
      tstrb_p1 <= s_axis.tstrb;
      tuser_p1 <= tuser_p0;
      tlast_p1 <= s_axis.tlast;
    end else if (m_axis.tready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign m_axis.tvalid = vld_p1;
  assign m_axis.tdata  = tdata_p1;
  assign m_axis.tstrb  = tstrb_p1;
  assign m_axis.tuser  = tuser_p1;
  assign m_axis.tlast  = tlast_p1;

`ifdef MAC_LOOKUP_STATS_EN
  logic        hit_evt, miss_evt, learn_evt;
  logic [31:0] hit_cnt_q, miss_cnt_q, learn_cnt_q;

  assign hit_evt   = lkp_acc && !is_bcast && lkp_hit;
  assign miss_evt  = lkp_acc && !is_bcast && !lkp_hit;
  assign learn_evt = lrn_wr && !lrn_hit;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      hit_cnt_q   <= 32'h0;
      miss_cnt_q  <= 32'h0;
      learn_cnt_q <= 32'h0;
    end else begin
      if (hit_evt)   hit_cnt_q   <= hit_cnt_q + 32'h1;
      if (miss_evt)  miss_cnt_q  <= miss_cnt_q + 32'h1;
      if (learn_evt) learn_cnt_q <= learn_cnt_q + 32'h1;
    end
  end

  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;
  assign learn_count = learn_cnt_q;
`else
  assign hit_count   = 32'h0;
  assign miss_count  = 32'h0;
  assign learn_count = 32'h0;
`endif

endmodule

// File: tb/tb_ualink_mac_lookup.sv
// Directed bench for ualink_mac_lookup: learning, lookup, filtering, replacement, backpressure, reset.
module tb_ualink_mac_lookup;

  localparam logic [95:0]  U0_HI  = 96'hFEED_0000_1111_2222_3333_4444;
  localparam logic [15:0]  U0_LO  = 16'hBEEF;
  localparam logic [127:0] U_REST = 128'h0000_0000_0000_0000_0000_0000_C300_0000;
  localparam logic [47:0]  MC     = 48'h01AA_BBCC_DDEE;  // multicast source, never learned
  localparam logic [47:0]  UNK    = 48'h1122_3344_5566;
  localparam logic [47:0]  M1     = 48'h0A0B_0C0D_0E01;
  localparam logic [47:0]  M2     = 48'h0A0B_0C0D_0E02;
  localparam logic [47:0]  M3     = 48'h0A0B_0C0D_0E03;
  localparam logic [47:0]  M4     = 48'h0A0B_0C0D_0E04;
  localparam logic [47:0]  M5     = 48'h0A0B_0C0D_0E05;
`ifdef MAC_LOOKUP_STATS_EN
  localparam logic [31:0]  STATS_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0]  STATS_MASK = 32'h0;
`endif

  typedef struct {
    logic [63:0]  d;
    logic [7:0]   s;
    logic [127:0] u;
    logic         l;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] hit_count, miss_count, learn_count;
  int          n_checks = 0;
  int          n_err    = 0;
  beat_t       mon_q[$];
  logic        stab_en = 1'b0;
  logic        stall_prev = 1'b0;
  logic [63:0] held_d;
  logic [127:0] held_u;
  logic        held_l;
  logic        bp_done;
  int          tog_c;

  ualink_mac_lookup_if #(.DATA_W(64), .USER_W(128)) s_if ();
  ualink_mac_lookup_if #(.DATA_W(64), .USER_W(128)) m_if ();

  ualink_mac_lookup #(
    .C_AXIS_DATA_WIDTH(64), .C_AXIS_TUSER_WIDTH(128), .NUM_ENTRIES(4)
  ) dut (
    .axi_aclk(clk), .axi_resetn(rst_n), .s_axis(s_if), .m_axis(m_if),
    .hit_count(hit_count), .miss_count(miss_count), .learn_count(learn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cexp(input int n);
    return 32'(n) & STATS_MASK;
  endfunction

  function automatic logic [63:0] w0_of(input logic [47:0] s, input logic [47:0] d);
    return {s[15:0], d};
  endfunction

  function automatic logic [63:0] w1_of(input logic [47:0] s);
    return {32'h0000_0008, s[47:16]};
  endfunction

  function automatic logic [63:0] beat_data(input int i, input logic [63:0] w0, input logic [63:0] w1);
    if (i == 0) return w0;
    if (i == 1) return w1;
    return {48'hDA7A_5EED_0000, 16'(i)};
  endfunction

  always @(negedge clk) begin
    if (rst_n && m_if.tvalid && m_if.tready)
      mon_q.push_back('{d: m_if.tdata, s: m_if.tstrb, u: m_if.tuser, l: m_if.tlast});
    if (stab_en && stall_prev) begin
      check("hold.vld",  128'(m_if.tvalid), 128'(1'b1));
      check("hold.data", 128'(m_if.tdata),  128'(held_d));
      check("hold.user", m_if.tuser,        held_u);
      check("hold.last", 128'(m_if.tlast),  128'(held_l));
    end
    stall_prev <= rst_n && m_if.tvalid && !m_if.tready;
    held_d     <= m_if.tdata;
    held_u     <= m_if.tuser;
    held_l     <= m_if.tlast;
  end

  task automatic send_beat(input logic [63:0] d, input logic [127:0] u, input logic [7:0] s, input logic l);
    logic acc;
    int   guard;
    s_if.tdata  = d;
    s_if.tuser  = u;
    s_if.tstrb  = s;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      acc = s_if.tready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) check("send.tmo", 128'(acc), 128'(1'b1));
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [63:0] w0, input logic [63:0] w1, input logic [7:0] src, input int nbeats);
    for (int i = 0; i < nbeats; i++)
      send_beat(beat_data(i, w0, w1),
                (i == 0) ? {U0_HI, 8'h00, src, U0_LO} : U_REST,
                (i == nbeats - 1) ? 8'h0F : 8'hFF,
                i == nbeats - 1);
  endtask

  task automatic check_pkt(input string tag, input logic [63:0] w0, input logic [7:0] src,
                           input logic [7:0] dst, input int nbeats);
    check({tag, ".nbeats"}, 128'(mon_q.size()), 128'(nbeats));
    if (mon_q.size() >= 1) begin
      check({tag, ".w0"},  128'(mon_q[0].d), 128'(w0));
      check({tag, ".dst"}, 128'(mon_q[0].u[31:24]), 128'(dst));
      check({tag, ".u0"},  mon_q[0].u, {U0_HI, dst, src, U0_LO});
    end
    if (mon_q.size() >= 2) check({tag, ".u1"}, mon_q[1].u, U_REST);
    if (mon_q.size() == nbeats) begin
      check({tag, ".last"}, 128'(mon_q[nbeats-1].l), 128'(1'b1));
      check({tag, ".strb"}, 128'(mon_q[nbeats-1].s), 128'(8'h0F));
    end
  endtask

  task automatic run_pkt(input string tag, input logic [63:0] w0, input logic [63:0] w1,
                         input logic [7:0] src, input int nbeats, input logic [7:0] dst);
    mon_q.delete();
    send_pkt(w0, w1, src, nbeats);
    repeat (3) @(posedge clk);
    #1;
    check_pkt(tag, w0, src, dst, nbeats);
  endtask

  task automatic check_cnt(input string tag, input int h, input int m, input int l);
    check({tag, ".hit"},   128'(hit_count),   128'(cexp(h)));
    check({tag, ".miss"},  128'(miss_count),  128'(cexp(m)));
    check({tag, ".learn"}, 128'(learn_count), 128'(cexp(l)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = '0;
    s_if.tstrb  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.vld",  128'(m_if.tvalid), 128'(1'b0));
    check("rst.data", 128'(m_if.tdata),  128'(64'h0));
    check("rst.user", m_if.tuser,        128'h0);
    check("rst.last", 128'(m_if.tlast),  128'(1'b0));
    check_cnt("rst", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst.ready", 128'(s_if.tready), 128'(1'b1));

    // Source EFBEEFBEEFBE has bit 40 set (top byte 0xEF), so it floods and is not learned.
    run_pkt("pktA", 64'hEFBE_FECA_FECA_FECA, 64'h0000_0008_EFBE_EFBE, 8'h04, 34, 8'h51);
    check_cnt("pktA", 0, 1, 0);
    run_pkt("learn", w0_of(M1, UNK), w1_of(M1), 8'h02, 4, 8'h55);
    check_cnt("learn", 0, 2, 1);
    run_pkt("hit", w0_of(MC, M1), w1_of(MC), 8'h01, 3, 8'h02);
    check_cnt("hit", 1, 2, 1);
    run_pkt("filter", w0_of(MC, M1), w1_of(MC), 8'h02, 3, 8'h00);
    check_cnt("filter", 2, 2, 1);
    run_pkt("bcast", w0_of(MC, 48'hFFFF_FFFF_FFFF), w1_of(MC), 8'h10, 3, 8'h45);
    check_cnt("bcast", 2, 2, 1);
    run_pkt("onebeat", w0_of(M3, UNK), w1_of(M3), 8'h08, 1, 8'h55);
    check_cnt("onebeat", 2, 3, 1);
    run_pkt("mcsrc", w0_of(MC, 48'hEFBE_EFBE_EFBE), w1_of(MC), 8'h01, 2, 8'h54);
    check_cnt("mcsrc", 2, 4, 1);

    run_pkt("rep2", w0_of(M2, UNK), w1_of(M2), 8'h40, 2, 8'h15);
    run_pkt("rep3", w0_of(M3, UNK), w1_of(M3), 8'h20, 2, 8'h55);
    run_pkt("rep4", w0_of(M4, UNK), w1_of(M4), 8'h08, 2, 8'h55);
    run_pkt("rep5", w0_of(M5, UNK), w1_of(M5), 8'h10, 2, 8'h45);
    check_cnt("rep", 2, 8, 5);
    run_pkt("evicted", w0_of(MC, M1), w1_of(MC), 8'h01, 2, 8'h54);
    run_pkt("kept", w0_of(MC, M2), w1_of(MC), 8'h01, 2, 8'h40);
    check_cnt("evict", 3, 9, 5);
    run_pkt("move", w0_of(M2, UNK), w1_of(M2), 8'h80, 2, 8'h55);
    run_pkt("moved", w0_of(MC, M2), w1_of(MC), 8'h01, 2, 8'h80);
    check_cnt("move", 4, 10, 5);

    bp_done = 1'b0;
    tog_c   = 0;
    stab_en = 1'b1;
    mon_q.delete();
    fork
      begin
        send_pkt(w0_of(MC, M2), w1_of(MC), 8'h04, 34);
        bp_done = 1'b1;
      end
      begin
        while (!bp_done && tog_c < 2000) begin
          @(posedge clk);
          #1;
          m_if.tready = (tog_c % 3) != 0;
          tog_c++;
        end
        m_if.tready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    stab_en = 1'b0;
    check_pkt("bp", w0_of(MC, M2), 8'h04, 8'h80, 34);
    for (int i = 0; i < 34; i++) begin
      if (i < mon_q.size()) begin
        check($sformatf("bp.d%0d", i), 128'(mon_q[i].d), 128'(beat_data(i, w0_of(MC, M2), w1_of(MC))));
        check($sformatf("bp.l%0d", i), 128'(mon_q[i].l), 128'(i == 33));
      end
    end
    check_cnt("bp", 5, 10, 5);

    s_if.tvalid = 1'b1;
    s_if.tstrb  = 8'hFF;
    s_if.tlast  = 1'b0;
    s_if.tdata  = w0_of(MC, M2);
    s_if.tuser  = {U0_HI, 8'h00, 8'h01, U0_LO};
    @(posedge clk); #1;
    s_if.tdata  = w1_of(MC);
    s_if.tuser  = U_REST;
    @(posedge clk); #1;
    s_if.tdata  = beat_data(2, 64'h0, 64'h0);
    @(posedge clk); #1;
    check("arst.pre_vld", 128'(m_if.tvalid), 128'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    check("arst.vld",  128'(m_if.tvalid), 128'(1'b0));
    check("arst.data", 128'(m_if.tdata),  128'(64'h0));
    check_cnt("arst", 0, 0, 0);
    s_if.tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_pkt("post_rst", w0_of(MC, M2), w1_of(MC), 8'h01, 2, 8'h54);
    check_cnt("post_rst", 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
